// File: rtl/ws2812_pixel_ser.sv
// ws2812_pixel_ser: serialises 24-bit colour words MSB first into the bit-timing stage, then latch gap per frame.
// Latency: accepted word -> first bit_rdy_out next cycle; bit_done_in -> next bit_rdy_out / ready / LATCH next cycle.
// Backpressure: pixel_ready_out only in IDLE; a pending word waits upstream while bits or the latch gap are in progress.
//
// Ports: clk_in, rst_in (sync, active-high); pixel_valid_in/pixel_data_in[23:0]/pixel_last_in/pixel_ready_out
//        upstream word handshake; bit_rdy_out/bit_data_out/bit_done_in bit-slot handshake; frame_done_out pulse.
// Config: define WS2812_RGB_SWAP_EN to reorder an {R,G,B} input word to {G,R,B} on load.
module ws2812_pixel_ser #(
  parameter logic [15:0] CNT_LATCH = 16'd12000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        pixel_valid_in,
  input  logic [23:0] pixel_data_in,
  input  logic        pixel_last_in,
  output logic        pixel_ready_out,
  input  logic        bit_done_in,
  output logic        bit_rdy_out,
  output logic        bit_data_out,
  output logic        frame_done_out
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3
  } state_t;

  state_t      state_q;
  state_t      state_nxt;
  logic [23:0] shift_q;
  logic [4:0]  idx_q;
  logic [15:0] cnt_q;
  logic        last_q;
  logic        por_q;        // set while the gap in progress is the post-reset one
  logic        frame_done_q;
  logic [23:0] load_word;
  logic        accept;
  logic        last_bit;
  logic        gap_end;

`ifdef WS2812_RGB_SWAP_EN
  // LEDs expect green first: {R,G,B} -> {G,R,B}
  assign load_word = {pixel_data_in[15:8], pixel_data_in[23:16], pixel_data_in[7:0]};
`else
  assign load_word = pixel_data_in;
`endif

  assign accept   = pixel_valid_in && pixel_ready_out;
  assign last_bit = (idx_q == 5'd23);
  assign gap_end  = (cnt_q == (CNT_LATCH - 16'd1));

  // State register; reset lands in LATCH so the line idles low for a full gap first.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_LATCH;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_nxt = ST_SEND;
      ST_SEND:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bit_done_in) begin
          if (!last_bit)   state_nxt = ST_SEND;
          else if (last_q) state_nxt = ST_LATCH;
          else             state_nxt = ST_IDLE;
        end
      end
      ST_LATCH: if (gap_end) state_nxt = ST_IDLE;
      default:  state_nxt = ST_LATCH;
    endcase
  end

  // Datapath: shift register, bit index, gap counter and frame-done flop.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shift_q      <= 24'd0;
      idx_q        <= 5'd0;
      cnt_q        <= 16'd0;
      last_q       <= 1'b0;
      por_q        <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shift_q <= load_word;
            last_q  <= pixel_last_in;
            idx_q   <= 5'd0;
          end
        end
        ST_WAIT: begin
          if (bit_done_in) begin
            if (!last_bit) begin
              shift_q <= {shift_q[22:0], 1'b0};
              idx_q   <= idx_q + 5'd1;
            end else if (last_q) begin
              cnt_q <= 16'd0;
            end
          end
        end
        ST_LATCH: begin
          // The compare ends the gap before the counter could wrap.
          cnt_q <= cnt_q + 16'd1;
          if (gap_end) begin
            frame_done_q <= !por_q;
            por_q        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode flops only, so no input-to-output combinational path exists.
  always_comb begin
    pixel_ready_out = (state_q == ST_IDLE);
    bit_rdy_out     = (state_q == ST_SEND);
    bit_data_out    = shift_q[23] && ((state_q == ST_SEND) || (state_q == ST_WAIT));
    frame_done_out  = frame_done_q;
  end

endmodule
